// File: rtl/hazard_ctrl_pipe_pkg.sv
// Shared types and encodings for the pipeline control/hazard block.
package hazard_ctrl_pipe_pkg;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/hazard_ctrl_pipe_fwd_sel.sv
// Forwarding select for one ALU operand; the younger EX/MEM producer wins over MEM/WB.
module hazard_ctrl_pipe_fwd_sel
  import hazard_ctrl_pipe_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_regwrite,
  input  logic [RA_W-1:0] wb_rd,
  output logic [1:0]      sel
);

  always_comb begin
    sel = FWD_REG;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Carries decoder control through ID/EX, EX/MEM, MEM/WB; handles load-use stalls,
// taken-branch flushes, forwarding selects and saturating event counters.
module hazard_ctrl_pipe
  import hazard_ctrl_pipe_pkg::*;
#(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic [1:0]       id_aluop,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_zero,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_memtoreg,
  output logic             ex_memwrite,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic [1:0]       ex_aluop,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_memtoreg,
  output logic             mem_regwrite,
  output logic [RA_W-1:0]  mem_rd,
  output logic             wb_memtoreg,
  output logic             wb_regwrite,
  output logic [RA_W-1:0]  wb_rd,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  ctrl_t            ex_q, ex_d, id_ctrl;
  logic [RA_W-1:0]  ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic [RA_W-1:0]  ex_rs1_d, ex_rs2_d, ex_rd_d;
  logic             mem_memread_q, mem_memwrite_q, mem_memtoreg_q, mem_regwrite_q;
  logic [RA_W-1:0]  mem_rd_q;
  logic             wb_memtoreg_q, wb_regwrite_q;
  logic [RA_W-1:0]  wb_rd_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             load_use;

  assign flush    = ex_q.branch & ex_zero;
  assign load_use = ex_q.memread && (ex_rd_q != '0) && id_valid &&
                    ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
  // A squashed ID instruction must never hold the front end.
  assign stall    = load_use & ~flush;

  always_comb begin
    id_ctrl          = BUBBLE;
    id_ctrl.branch   = id_branch;
    id_ctrl.memread  = id_memread;
    id_ctrl.memtoreg = id_memtoreg;
    id_ctrl.aluop    = id_aluop;
    id_ctrl.memwrite = id_memwrite;
    id_ctrl.alusrc   = id_alusrc;
    id_ctrl.regwrite = id_regwrite;

    ex_d     = id_ctrl;
    ex_rs1_d = id_rs1;
    ex_rs2_d = id_rs2;
    ex_rd_d  = id_rd;
    if (flush || stall || !id_valid) begin
      ex_d     = BUBBLE;
      ex_rs1_d = '0;
      ex_rs2_d = '0;
      ex_rd_d  = '0;
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != CntMax)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q           <= BUBBLE;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_memtoreg_q  <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= '0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      ex_q           <= ex_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      mem_memread_q  <= ex_q.memread;
      mem_memwrite_q <= ex_q.memwrite;
      mem_memtoreg_q <= ex_q.memtoreg;
      mem_regwrite_q <= ex_q.regwrite;
      mem_rd_q       <= ex_rd_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_rd_q        <= mem_rd_q;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  hazard_ctrl_pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .rs          (ex_rs1_q),
    .mem_regwrite(mem_regwrite_q),
    .mem_rd      (mem_rd_q),
    .wb_regwrite (wb_regwrite_q),
    .wb_rd       (wb_rd_q),
    .sel         (fwd_a)
  );

  hazard_ctrl_pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .rs          (ex_rs2_q),
    .mem_regwrite(mem_regwrite_q),
    .mem_rd      (mem_rd_q),
    .wb_regwrite (wb_regwrite_q),
    .wb_rd       (wb_rd_q),
    .sel         (fwd_b)
  );

  assign ex_branch    = ex_q.branch;
  assign ex_memread   = ex_q.memread;
  assign ex_memtoreg  = ex_q.memtoreg;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_aluop     = ex_q.aluop;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;
  assign mem_memread  = mem_memread_q;
  assign mem_memwrite = mem_memwrite_q;
  assign mem_memtoreg = mem_memtoreg_q;
  assign mem_regwrite = mem_regwrite_q;
  assign mem_rd       = mem_rd_q;
  assign wb_memtoreg  = wb_memtoreg_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_rd        = wb_rd_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Scoreboard bench: instruction-level pipeline model pushes expected outputs each cycle,
// a negedge monitor pops and compares against the DUT.
module tb_hazard_ctrl_pipe;

  localparam int RA_W  = 5;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
  logic [1:0] id_aluop;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic ex_zero;
  logic ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
  logic [1:0] ex_aluop;
  logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
  logic [RA_W-1:0] mem_rd;
  logic wb_memtoreg, wb_regwrite;
  logic [RA_W-1:0] wb_rd;
  logic stall, flush;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_pipe #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_branch(id_branch),
    .id_memread(id_memread), .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_aluop(id_aluop),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
    .ex_aluop(ex_aluop), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .wb_memtoreg(wb_memtoreg),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .stall(stall), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    bit       valid;
    bit       br, mr, mtr, mw, as, rw;
    bit [1:0] aluop;
    bit [4:0] rs1, rs2, rd;
  } instr_t;

  typedef struct {
    bit [7:0]  ex_ctrl;
    bit [14:0] ex_regs;
    bit [8:0]  mem;
    bit [6:0]  wb;
    bit        stall, flush;
    bit [1:0]  fa, fb;
    int        scnt, fcnt;
  } exp_t;

  instr_t pipe [3];  // 0 = EX, 1 = MEM, 2 = WB
  instr_t cur;
  bit     zero;
  int     m_scnt, m_fcnt;
  bit     m_stall, m_flush;
  exp_t   sbq[$];
  exp_t   mon_e;
  int     checks = 0;
  int     failures = 0;

  function automatic instr_t nop();
    instr_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic instr_t mk(bit br, bit mr, bit rw, bit [4:0] rs1, bit [4:0] rs2,
                                bit [4:0] rd);
    instr_t i;
    i = '{default: 0};
    i.valid = 1; i.br = br; i.mr = mr; i.mtr = mr; i.rw = rw;
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.aluop = br ? 2'b01 : 2'b10;
    return i;
  endfunction

  // Nearest older in-flight writer of a nonzero register supplies the operand.
  function automatic bit [1:0] fwd_of(bit [4:0] rs);
    for (int s = 1; s <= 2; s++) begin
      if (rs != 0 && pipe[s].rw && pipe[s].rd == rs) return (s == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endfunction

  task automatic cycle(bit rst);
    exp_t e;
    rst_n = !rst;
    id_valid = cur.valid; id_branch = cur.br; id_memread = cur.mr; id_memtoreg = cur.mtr;
    id_memwrite = cur.mw; id_alusrc = cur.as; id_regwrite = cur.rw; id_aluop = cur.aluop;
    id_rs1 = cur.rs1; id_rs2 = cur.rs2; id_rd = cur.rd; ex_zero = zero;
    m_flush = pipe[0].br && zero;
    m_stall = !m_flush && cur.valid && pipe[0].mr && pipe[0].rd != 0 &&
              (pipe[0].rd == cur.rs1 || pipe[0].rd == cur.rs2);
    e.ex_ctrl = {pipe[0].br, pipe[0].mr, pipe[0].mtr, pipe[0].aluop, pipe[0].mw,
                 pipe[0].as, pipe[0].rw};
    e.ex_regs = {pipe[0].rs1, pipe[0].rs2, pipe[0].rd};
    e.mem     = {pipe[1].mr, pipe[1].mw, pipe[1].mtr, pipe[1].rw, pipe[1].rd};
    e.wb      = {pipe[2].mtr, pipe[2].rw, pipe[2].rd};
    e.stall   = m_stall;
    e.flush   = m_flush;
    e.fa      = fwd_of(pipe[0].rs1);
    e.fb      = fwd_of(pipe[0].rs2);
    e.scnt    = m_scnt;
    e.fcnt    = m_fcnt;
    sbq.push_back(e);
    @(posedge clk);
    if (rst) begin
      foreach (pipe[i]) pipe[i] = nop();
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      if (m_stall && m_scnt < CMAX) m_scnt++;
      if (m_flush && m_fcnt < CMAX) m_fcnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (m_flush || m_stall || !cur.valid) ? nop() : cur;
    end
    #1;
  endtask

  task automatic issue(instr_t i, bit z);
    cur  = i;
    zero = z;
    cycle(0);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("ex_ctrl", {ex_branch, ex_memread, ex_memtoreg, ex_aluop, ex_memwrite, ex_alusrc,
                      ex_regwrite}, mon_e.ex_ctrl);
      chk("ex_regs", {ex_rs1, ex_rs2, ex_rd}, mon_e.ex_regs);
      chk("mem", {mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_rd}, mon_e.mem);
      chk("wb", {wb_memtoreg, wb_regwrite, wb_rd}, mon_e.wb);
      chk("stall", stall, mon_e.stall);
      chk("flush", flush, mon_e.flush);
      chk("fwd_a", fwd_a, mon_e.fa);
      chk("fwd_b", fwd_b, mon_e.fb);
      chk("stall_cnt", stall_cnt, mon_e.scnt);
      chk("flush_cnt", flush_cnt, mon_e.fcnt);
    end
  end

  initial begin
    instr_t ones, r;
    bit prev_stall, prev_flush;
    ones = '{default: 1};
    ones.rs1 = 5'd31; ones.rs2 = 5'd31; ones.rd = 5'd31; ones.aluop = 2'b11;
    cur = ones; zero = 1;
    rst_n = 1'b0;
    id_valid = 1; id_branch = 1; id_memread = 1; id_memtoreg = 1; id_memwrite = 1;
    id_alusrc = 1; id_regwrite = 1; id_aluop = 2'b11; id_rs1 = '1; id_rs2 = '1; id_rd = '1;
    ex_zero = 1;
    @(posedge clk);
    #1;
    foreach (pipe[i]) pipe[i] = nop();
    m_scnt = 0; m_fcnt = 0;
    cycle(1);                      // second reset cycle, id_* all ones
    issue(ones, 0);                // first cycle out of reset
    issue(nop(), 0);               // all-ones bundle now in EX
    issue(nop(), 0);
    issue(nop(), 0);

    // load-use, then forwarding from MEM/WB
    issue(mk(0, 1, 1, 1, 0, 5), 0);
    issue(mk(0, 0, 1, 5, 6, 8), 0);
    issue(mk(0, 0, 1, 5, 6, 8), 0);
    issue(nop(), 0);
    issue(nop(), 0);

    // taken and not-taken branch
    issue(mk(1, 0, 0, 1, 2, 0), 0);
    issue(mk(0, 0, 1, 3, 4, 9), 1);
    issue(nop(), 0);
    issue(mk(1, 0, 0, 1, 2, 0), 0);
    issue(mk(0, 0, 1, 3, 4, 9), 0);
    issue(nop(), 0);

    // flush beats stall
    issue(mk(1, 1, 0, 1, 2, 3), 0);
    issue(mk(0, 0, 1, 4, 3, 10), 1);
    issue(nop(), 0);

    // forward priority and x0 exclusion
    issue(mk(0, 0, 1, 1, 2, 7), 0);
    issue(mk(0, 0, 1, 1, 2, 7), 0);
    issue(mk(0, 0, 1, 7, 7, 11), 0);
    issue(nop(), 0);
    issue(mk(0, 0, 1, 1, 2, 0), 0);
    issue(mk(0, 0, 1, 1, 2, 0), 0);
    issue(mk(0, 0, 1, 0, 0, 11), 0);
    issue(mk(0, 1, 1, 0, 0, 0), 0);
    issue(mk(0, 0, 1, 0, 0, 12), 0);
    issue(nop(), 0);

    // randomized traffic: stalled instructions are re-presented, flushed slots go empty
    prev_stall = 0; prev_flush = 0;
    r = nop();
    for (int n = 0; n < 3000; n++) begin
      if (!prev_stall) begin
        r = nop();
        r.valid = !prev_flush && ($urandom_range(0, 7) != 0);
        r.br = ($urandom_range(0, 3) == 0); r.mr = ($urandom_range(0, 2) == 0);
        r.mtr = $urandom_range(0, 1); r.mw = $urandom_range(0, 1);
        r.as = $urandom_range(0, 1); r.rw = $urandom_range(0, 1);
        r.aluop = 2'($urandom_range(0, 3));
        r.rs1 = 5'($urandom_range(0, 3)); r.rs2 = 5'($urandom_range(0, 3));
        r.rd = 5'($urandom_range(0, 3));
      end
      cur = r;
      zero = $urandom_range(0, 1);
      cycle($urandom_range(0, 199) == 0);
      prev_stall = m_stall && rst_n;
      prev_flush = m_flush && rst_n;
    end
    issue(nop(), 0);
    issue(nop(), 0);

    // counter saturation: more than 2^CNT_W events of each kind
    for (int n = 0; n < 19; n++) begin
      issue(mk(0, 1, 1, 0, 0, 5), 0);
      issue(mk(0, 0, 1, 5, 0, 6), 0);
    end
    for (int n = 0; n < 19; n++) begin
      issue(mk(1, 0, 0, 1, 2, 0), 0);
      issue(mk(0, 0, 1, 1, 2, 6), 1);
    end
    issue(nop(), 0);
    issue(nop(), 0);

    #20;
    chk("scoreboard_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_pipe.md
Name: hazard_ctrl_pipe

Overview:
- Consumer side of the opcode decoder's control bundle (Branch, MemRead, MemToReg, ALUOp, MemWrite, ALUSrc, RegWrite).
- Carries the bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers with the destination register index.
- Detects load-use hazards and inserts bubbles; flushes on taken branch (resolved in EX); produces forwarding selects; counts stalls and flushes.
- Sits between the decoder and the datapath stage registers of the 5-stage core.

Parameters:
- RA_W, 5, register-address width
- CNT_W, 16, width of the stall and flush statistics counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction (0 after reset or flush)
- id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  decoder outputs for the ID instruction
- id_aluop  in  2  decoder ALUOp
- id_rs1, id_rs2, id_rd  in  RA_W each  register fields of the ID instruction
- ex_zero  in  1  ALU zero flag of the EX instruction
- ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  ID/EX control
- ex_aluop  out  2  ID/EX ALUOp
- ex_rs1, ex_rs2, ex_rd  out  RA_W each  ID/EX register fields
- mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite  out  1 each  EX/MEM control
- mem_rd  out  RA_W  EX/MEM destination register
- wb_memtoreg, wb_regwrite  out  1 each  MEM/WB control
- wb_rd  out  RA_W  MEM/WB destination register
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- flush  out  1  squash IF/ID this cycle (combinational)
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset: all stage registers, including every ex_/mem_/wb_ output, are cleared to 0 at the rising clk edge while rst_n=0. Counters are also cleared. After reset, stall=flush=0 and fwd_a=fwd_b=00.
- Reset mid-operation discards all in-flight control; there is no partial retention.
- flush = ex_branch & ex_zero.
- Stall is asserted when all of the following hold:
  - ex_memread=1 and ex_rd != 0 and id_valid=1
  - (ex_rd == id_rs1 or ex_rd == id_rs2)
  - flush=0 (flush has priority; a squashed instruction never stalls)
- ID/EX load each edge:
  - Loads a bubble (all control 0, rs/rd fields 0) if flush=1, stall=1 or id_valid=0.
  - Otherwise loads the id_* bundle verbatim.
- EX/MEM and MEM/WB shift unconditionally every cycle; there is no global hold.
- Latency: an id_* bundle appears on ex_* one cycle later, on mem_* two cycles later and on wb_* three cycles later.
- Stall lasts exactly one cycle per load-use pair, because the bubble clears ex_memread.
- Forwarding (fwd_a shown; fwd_b is identical using ex_rs2):
  - 10 if mem_regwrite and mem_rd != 0 and mem_rd == ex_rs1.
  - Else 01 if wb_regwrite and wb_rd != 0 and wb_rd == ex_rs1.
  - Else 00.
  - EX/MEM beats MEM/WB when both match.
- x0 is never a hazard or forward source.
- Counters increment by 1 on each clock edge where stall (resp. flush) is 1. They saturate at all-ones with no wrap.
- Simultaneous stall and flush conditions: only flush is asserted, flush_cnt increments, stall_cnt is unchanged.

Decomposition:
- Shared package holds:
  - the control bundle struct: branch, memread, memtoreg, aluop[1:0], memwrite, alusrc, regwrite
  - the BUBBLE constant (all zero)
  - the FWD_REG / FWD_MEM / FWD_WB encodings (00/10/01)
- One sub-module, fwd_sel, is natural: a combinational forwarding select for one operand, instantiated twice.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_* all 1 -> every output 0, stall_cnt=flush_cnt=0. Release -> ex_* equals id_* after 1 cycle.
- Load-use: lw x5 (memread=1, rd=5), then add with rs1=5 -> stall=1 for exactly 1 cycle, ex_* bubble next cycle, stall_cnt=1. Then add reaches EX with fwd_a=01.
- Taken branch: ex_branch=1, ex_zero=1 -> flush=1 that cycle, ex_* all 0 next cycle, flush_cnt=1. With ex_zero=0 -> flush=0 and the ID bundle propagates.
- Flush vs stall: ex_branch=1, ex_zero=1, ex_memread=1, ex_rd=3, id_rs2=3 -> stall=0, flush=1, stall_cnt unchanged.
- Forward priority: mem_rd=7 with regwrite, wb_rd=7 with regwrite, ex_rs1=7 -> fwd_a=10. With rd=0 in both -> fwd_a=00.
- Saturation: force 2^CNT_W+3 stalls (CNT_W=4 build: 19 stalls) -> stall_cnt=15, no wrap.
